cache_mem: RTL and testbench

CACHE_MEM -- requirements
Module: cache_mem

---
 rtl/cache_mem_if.sv | 34 +++
 rtl/cache_mem.sv | 83 ++++++++
 tb/tb_cache_mem.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cache_mem_if.sv
// cache_mem_if: command and response bundle between a controller and cache_mem.
// Controller drives: select_in, write_in, delete_in, idx_in, key_in, value_in.
// Cache drives: used, hit, hit_idx, value_out (registered), free_idx, full
// (combinational from used), rsp_valid and err (one-cycle pulses).
interface cache_mem_if #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 32
) ();
    logic                   select_in;
    logic                   write_in;
    logic                   delete_in;
    logic [NUM_ENTRIES-1:0] idx_in;
    logic [KEY_WIDTH-1:0]   key_in;
    logic [VALUE_WIDTH-1:0] value_in;
    logic [NUM_ENTRIES-1:0] used;
    logic                   hit;
    logic [NUM_ENTRIES-1:0] hit_idx;
    logic [VALUE_WIDTH-1:0] value_out;
    logic [NUM_ENTRIES-1:0] free_idx;
    logic                   full;
    logic                   rsp_valid;
    logic                   err;

    modport master (
        output select_in, write_in, delete_in, idx_in, key_in, value_in,
        input  used, hit, hit_idx, value_out, free_idx, full, rsp_valid, err
    );

    modport slave (
        input  select_in, write_in, delete_in, idx_in, key_in, value_in,
        output used, hit, hit_idx, value_out, free_idx, full, rsp_valid, err
    );
endinterface

// File: rtl/cache_mem.sv
// cache_mem: fully associative key/value store with lookup, write and delete.
// Ports: clk, rst_n (synchronous, active-low), bus (cache_mem_if.slave) carrying
// the command strobe/qualifiers, one-hot target index, key and value in, and
// used, hit, hit_idx, value_out, free_idx, full, rsp_valid, err out.
module cache_mem #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    cache_mem_if.slave bus
);
    logic [KEY_WIDTH-1:0]   keys   [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] values [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] used_q, hit_idx_q, match;
    logic [VALUE_WIDTH-1:0] value_q, match_value;
    logic                   hit_q, rsp_q, err_q;
    logic                   one_hot, conflict, do_lookup, do_write, do_delete, reject;

    // Keys are unique among used entries, so at most one match bit is set and
    // OR-reducing the matching values yields that entry's value (or zero).
    always_comb begin
        match       = '0;
        match_value = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = used_q[i] && (keys[i] == bus.key_in);
            if (match[i]) match_value = match_value | values[i];
        end
    end

    assign one_hot   = (bus.idx_in != '0) && ((bus.idx_in & (bus.idx_in - NUM_ENTRIES'(1))) == '0);
    // A write may overwrite its own target, but must not duplicate a key held elsewhere.
    assign conflict  = |(match & ~bus.idx_in);
    assign do_lookup = bus.select_in && !bus.write_in && !bus.delete_in;
    assign do_write  = bus.select_in && bus.write_in && !bus.delete_in && one_hot && !conflict;
    assign do_delete = bus.select_in && bus.delete_in && !bus.write_in && one_hot;
    assign reject    = bus.select_in && (bus.write_in || bus.delete_in) && !do_write && !do_delete;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            used_q    <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            value_q   <= '0;
            rsp_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rsp_q <= bus.select_in;
            err_q <= reject;
            if (do_lookup) begin
                hit_q     <= |match;
                hit_idx_q <= match;
                value_q   <= match_value;
            end
            if (do_write) used_q <= used_q | bus.idx_in;
            else if (do_delete) used_q <= used_q & ~bus.idx_in;
        end
    end

    // Payload storage is not reset; the used bits alone define validity.
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (bus.idx_in[i]) begin
                    keys[i]   <= bus.key_in;
                    values[i] <= bus.value_in;
                end
            end
        end
    end

    // Adding one to used turns its lowest zero into a one; masking with ~used
    // isolates that bit, and the sum wraps to zero when every entry is used.
    assign bus.free_idx  = ~used_q & (used_q + NUM_ENTRIES'(1));
    assign bus.full      = &used_q;
    assign bus.used      = used_q;
    assign bus.hit       = hit_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.value_out = value_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_cache_mem.sv
// tb_cache_mem: directed table-driven bench for cache_mem plus sequences for fill, delete and reset corners.
module tb_cache_mem;
    typedef struct {
        logic        sel, wr, del;
        logic [15:0] idx, key;
        logic [31:0] val;
        logic [15:0] e_used;
        logic        e_rsp, e_err, e_hit;
        logic [15:0] e_hidx;
        logic [31:0] e_val;
        logic [15:0] e_free;
        logic        e_full;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [17];

    always #5 clk = ~clk;

    cache_mem_if #(.NUM_ENTRIES(16), .KEY_WIDTH(16), .VALUE_WIDTH(32)) bus ();

    cache_mem #(.NUM_ENTRIES(16), .KEY_WIDTH(16), .VALUE_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic sel, input logic wr, input logic del,
                       input logic [15:0] idx, input logic [15:0] key, input logic [31:0] val);
        @(negedge clk);
        bus.select_in = sel;
        bus.write_in  = wr;
        bus.delete_in = del;
        bus.idx_in    = idx;
        bus.key_in    = key;
        bus.value_in  = val;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " used"}, 32'(bus.used), 32'(v.e_used));
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(v.e_rsp));
        check({tag, " err"}, 32'(bus.err), 32'(v.e_err));
        check({tag, " hit"}, 32'(bus.hit), 32'(v.e_hit));
        check({tag, " hit_idx"}, 32'(bus.hit_idx), 32'(v.e_hidx));
        check({tag, " value_out"}, bus.value_out, v.e_val);
        check({tag, " free_idx"}, 32'(bus.free_idx), 32'(v.e_free));
        check({tag, " full"}, 32'(bus.full), 32'(v.e_full));
    endtask

    initial begin
        vec_t r;
        //            sel  wr    del   idx       key       val            used      rsp   err   hit   hidx      value          free      full
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 16'h00AA, 32'h12345678, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h00000000, 16'h0002, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h00AA, 32'h00000000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h12345678, 16'h0002, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h00BB, 32'h00000000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h00000000, 16'h0002, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h00AA, 32'h00000000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h00000000, 16'h0002, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h00AA, 32'h00000000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h12345678, 16'h0002, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h00AA, 32'h00000005, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 32'h12345678, 16'h0002, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0001, 16'h00AA, 32'h00000001, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h12345678, 16'h0002, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h00AA, 32'h00000000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h00CC, 32'h00000009, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h00CC, 32'h00000009, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0002, 16'h00CC, 32'h00000009, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h00CC, 32'h00000000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h00CC, 32'h00000000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'h00000000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 32'h00000001, 16'h0002, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 32'h00000000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h00000001, 16'h0001, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h00AA, 32'h00000000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h00000000, 16'h0001, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0001, 16'h00AA, 32'h12345678, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h00000000, 16'h0002, 1'b0};

        bus.select_in = 1'b1;
        bus.write_in  = 1'b1;
        bus.delete_in = 1'b0;
        bus.idx_in    = 16'h0001;
        bus.key_in    = 16'h0055;
        bus.value_in  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        r = '{1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 16'h0001, 1'b0};
        check_all("reset", r);
        rst_n = 1'b1;
        cmd(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
        check_all("post_reset", r);

        for (int i = 0; i < 17; i++) begin
            cmd(vecs[i].sel, vecs[i].wr, vecs[i].del, vecs[i].idx, vecs[i].key, vecs[i].val);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 1; i < 16; i++) begin
            cmd(1'b1, 1'b1, 1'b0, 16'(1 << i), 16'h0100 + 16'(i), 32'(i));
            check($sformatf("fill%0d err", i), 32'(bus.err), 32'h0);
        end
        check("fill used", 32'(bus.used), 32'h0000FFFF);
        check("fill full", 32'(bus.full), 32'h1);
        check("fill free_idx", 32'(bus.free_idx), 32'h0);

        cmd(1'b1, 1'b1, 1'b0, 16'h8000, 16'h0101, 32'hDEAD);
        check("dupkey err", 32'(bus.err), 32'h1);
        check("dupkey used", 32'(bus.used), 32'h0000FFFF);

        cmd(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0, 32'h0);
        check("del8 err", 32'(bus.err), 32'h0);
        check("del8 used", 32'(bus.used), 32'h0000FEFF);
        check("del8 free_idx", 32'(bus.free_idx), 32'h00000100);
        check("del8 full", 32'(bus.full), 32'h0);

        cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h0108, 32'h0);
        check("lookup deleted hit", 32'(bus.hit), 32'h0);
        check("lookup deleted hit_idx", 32'(bus.hit_idx), 32'h0);
        cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h010F, 32'h0);
        check("lookup 15 hit_idx", 32'(bus.hit_idx), 32'h00008000);
        check("lookup 15 value", bus.value_out, 32'h0000000F);
        cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h00AA, 32'h0);
        check("lookup 0 hit_idx", 32'(bus.hit_idx), 32'h00000001);
        check("lookup 0 value", bus.value_out, 32'h12345678);

        @(negedge clk);
        rst_n         = 1'b0;
        bus.select_in = 1'b1;
        bus.write_in  = 1'b1;
        bus.delete_in = 1'b0;
        bus.idx_in    = 16'h0001;
        bus.key_in    = 16'h0077;
        bus.value_in  = 32'h77;
        @(posedge clk);
        #1;
        check("rstwr used", 32'(bus.used), 32'h0);
        check("rstwr rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rstwr hit", 32'(bus.hit), 32'h0);
        check("rstwr value", bus.value_out, 32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.select_in = 1'b0;
        @(posedge clk);
        #1;
        check("rstwr next rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rstwr next free_idx", 32'(bus.free_idx), 32'h1);
        cmd(1'b1, 1'b0, 1'b0, 16'h0, 16'h0077, 32'h0);
        check("rstwr lookup rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("rstwr lookup hit", 32'(bus.hit), 32'h0);
        check("rstwr lookup value", bus.value_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
